cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller. It sits directly downstream of the `cpu` request generator and upstream of main memory. It accepts one-cycle `rd`/`wr` request pulses with byte enables and returns a one-cycle `ack`. It also keeps saturating hit/miss counters for the bench.

## Interface
Parameters:
- `INDEX_W`, 8: line index width; `2**INDEX_W` lines of one 32-bit word each.
- `ADDR_W`, 16: word address width; tag width is `ADDR_W-INDEX_W`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  16  CPU word address.
- `wr`  in  1  write request pulse.
- `rd`  in  1  read request pulse.
- `wdata`  in  32  write data.
- `bval`  in  4  byte enables; bit n selects `wdata[8n+7:8n]`.
- `ack`  out  1  request complete, one-cycle pulse.
- `rdata`  out  32  read data; valid when `ack` is high for a read.
- `mem_addr`  out  16  memory word address.
- `mem_rd`  out  1  memory read, held until `mem_ack`.
- `mem_wr`  out  1  memory write, held until `mem_ack`.
- `mem_wdata`  out  32  memory write data.
- `mem_bval`  out  4  memory byte enables.
- `mem_rdata`  in  32  memory read data; valid with `mem_ack`.
- `mem_ack`  in  1  memory completion pulse.
- `hit_cnt`  out  16  read+write hits, saturating at 16'hFFFF.
- `miss_cnt`  out  16  read+write misses, saturating at 16'hFFFF.

## Operation
- **FSM states:** IDLE, LOOKUP, MEM_RD, MEM_WR, RESP. All outputs are registered (Moore).
- **IDLE:**
  - On `rd|wr`, latch `addr`, `wdata`, `bval` and the op, then go to LOOKUP.
  - If `wr` and `rd` are both high, the request is a write.
- **LOOKUP:**
  - Compare the stored tag and valid bit at `addr[INDEX_W-1:0]`.
  - Read hit: `rdata` ← line data; `hit_cnt++`; go to RESP.
  - Read miss: `miss_cnt++`; go to MEM_RD.
  - Write hit: merge the enabled bytes into the line; `hit_cnt++`; go to MEM_WR.
  - Write miss: line untouched (no allocate); `miss_cnt++`; go to MEM_WR.
  - Write with `bval==0`: counted as a hit or miss as above; no line update; skips memory and goes to RESP.
- **MEM_RD:**
  - `mem_rd=1`, `mem_addr` = latched address.
  - On `mem_ack`: line ← `mem_rdata`, tag written, valid=1, `rdata` ← `mem_rdata`; go to RESP.
- **MEM_WR:**
  - `mem_wr=1`, with `mem_addr`, `mem_wdata` and `mem_bval` = latched values.
  - On `mem_ack`, go to RESP.
- **RESP:** `ack=1` for exactly one cycle, then go to IDLE.
- **Busy behaviour:** `rd`/`wr` arriving in any state other than IDLE is ignored, not queued.
- **Stray `mem_ack`:** ignored outside MEM_RD/MEM_WR.
- **Counters:** saturate and never wrap. At 16'hFFFF a further event leaves the value unchanged.

## Timing
- **Reset values:**
  - Asserting `reset` low immediately forces state IDLE and clears all valid bits.
  - `ack`, `mem_rd`, `mem_wr`, `hit_cnt`, `miss_cnt`, `rdata`, `mem_addr`, `mem_wdata` and `mem_bval` are all 0.
- **Reset mid-operation:**
  - An outstanding memory request is dropped and no `ack` is produced.
  - Tag and data contents are don't-care, since valid bits are cleared.
- **Latency (request sampled at edge 0):**
  - Read hit: `ack` high in cycle 2.
  - Read or write miss: `mem_rd`/`mem_wr` rise in cycle 2.
  - If `mem_ack` is sampled at edge k, `ack` is high in cycle k+1.
  - Write hit: same as a write miss (write-through).
- **Request acceptance:** a request pulse on the same edge that leaves RESP (IDLE next) is lost. The upstream source issues only after seeing `ack`, which makes this safe.
- **`rdata` hold:** `rdata` holds its value until the next read completes.

## Structure
- **Package `cache_pkg`:**
  - `INDEX_W` and `ADDR_W` defaults, plus the derived `TAG_W`.
  - FSM state enum.
  - Op encoding (OP_RD, OP_WR).
  - Byte-merge function `merge(old, new, bval)`.
- **Sub-module `cache_array`:**
  - Valid-bit flops with async clear.
  - Tag RAM and data RAM, with a single read port (index) and a single write port (index, tag, data, valid).
  - The controller FSM and counters stay in `cache_ctrl`.

## Test plan
1. **Cold read miss:** after reset release, `rd` with addr 16'h1234 → `mem_rd` with `mem_addr` 16'h1234; memory returns 32'hDEADBEEF → `ack` with `rdata` 32'hDEADBEEF; `miss_cnt`=1.
2. **Read hit:** repeat the read of 16'h1234 → no `mem_rd`; `ack` in cycle 2 with `rdata` 32'hDEADBEEF; `hit_cnt`=1.
3. **Write hit with byte merge:** `wr` to 16'h1234 with `wdata` 32'h000000AA, `bval` 4'b0001 → `mem_wr` with `mem_bval` 4'b0001; a subsequent read hits with `rdata` 32'hDEADBEAA.
4. **Write miss, no allocate:** `wr` to 16'h5634 (same index, different tag) → `mem_wr` issued; a following read of 16'h1234 still hits with 32'hDEADBEAA.
5. **Reset mid-operation:** assert `reset` low during MEM_RD → `mem_rd` drops at once and no `ack`; after release, a read of 16'h1234 misses.
6. **Counter saturation:** preload or force `hit_cnt` to 16'hFFFF, then issue a read hit → count stays 16'hFFFF. A simultaneous `rd`+`wr` pulse executes as a write.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM/op encodings and byte-merge helper for the cache controller.
package cache_pkg;
    localparam int INDEX_W_DEF = 8;
    localparam int ADDR_W_DEF  = 16;
    localparam int TAG_W_DEF   = ADDR_W_DEF - INDEX_W_DEF;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] bval);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = bval[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/cache_array.sv
// cache_array: tag/data storage with one async read port and one write port;
// valid bits are the only state cleared by reset.
module cache_array
    import cache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data,
    input  logic               wr_valid
);
    localparam int LINES = 2**INDEX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_ram  [LINES];
    logic [31:0]      data_ram [LINES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) valid <= '0;
        else if (we) valid[wr_idx] <= wr_valid;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_ram[wr_idx]  <= wr_tag;
            data_ram[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_ram[rd_idx];
    assign rd_data  = data_ram[rd_idx];
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller
// with saturating hit/miss counters.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic              rd,
    input  logic [31:0]       wdata,
    input  logic [3:0]        bval,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_bval,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W;

    state_t state, state_nx;
    op_t    op;
    logic              line_valid, hit, we;
    logic [TAG_W-1:0]  line_tag;
    logic [31:0]       line_data, wr_data;

    // mem_addr/mem_wdata/mem_bval double as the latched request registers
    cache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (mem_addr[INDEX_W-1:0]),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (we),
        .wr_idx   (mem_addr[INDEX_W-1:0]),
        .wr_tag   (mem_addr[ADDR_W-1:INDEX_W]),
        .wr_data  (wr_data),
        .wr_valid (1'b1)
    );

    assign hit     = line_valid && line_tag == mem_addr[ADDR_W-1:INDEX_W];
    assign we      = (state == LOOKUP && op == OP_WR && hit && |mem_bval) || (state == MEM_RD && mem_ack);
    assign wr_data = state == MEM_RD ? mem_rdata : merge(line_data, mem_wdata, mem_bval);
    assign ack     = state == RESP;
    assign mem_rd  = state == MEM_RD;
    assign mem_wr  = state == MEM_WR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:           state_nx = (rd | wr) ? LOOKUP : IDLE;
            LOOKUP:         state_nx = op == OP_RD ? (hit ? RESP : MEM_RD) : (|mem_bval ? MEM_WR : RESP);
            MEM_RD, MEM_WR: state_nx = mem_ack ? RESP : state;
            default:        state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op        <= OP_RD;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_bval  <= '0;
            rdata     <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            if (state == IDLE && (rd | wr)) begin
                op        <= wr ? OP_WR : OP_RD;
                mem_addr  <= addr;
                mem_wdata <= wdata;
                mem_bval  <= bval;
            end
            if (state == LOOKUP) begin
                if (hit) hit_cnt <= hit_cnt + {15'd0, ~&hit_cnt};
                else miss_cnt <= miss_cnt + {15'd0, ~&miss_cnt};
                if (op == OP_RD && hit) rdata <= line_data;
            end
            if (state == MEM_RD && mem_ack) rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: vector table, reset/saturation sequences and randomized traffic
// checked against an array-based cache model and a memory model.
module tb_cache_ctrl;
    logic        clk = 0, reset = 0;
    logic [15:0] addr = 0;
    logic        wr = 0, rd = 0;
    logic [31:0] wdata = 0;
    logic [3:0]  bval = 0;
    logic        ack;
    logic [31:0] rdata;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bval;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt, miss_cnt;

    cache_ctrl dut (
        .clk(clk), .reset(reset), .addr(addr), .wr(wr), .rd(rd), .wdata(wdata), .bval(bval),
        .ack(ack), .rdata(rdata), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_bval(mem_bval), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] b);
        logic [31:0] m;
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (old & ~m) | (nw & m);
    endfunction

    // main memory model
    logic [31:0] mem_m [logic [15:0]];
    int  mem_dly = 0, n_mrd = 0, n_mwr = 0;
    bit  mem_hold = 0, stray_en = 0;
    logic [15:0] l_addr;
    logic [31:0] l_wdata;
    logic [3:0]  l_bval;

    function automatic logic [31:0] mem_get(input logic [15:0] a);
        return mem_m.exists(a) ? mem_m[a] : {a, ~a};
    endfunction

    initial begin : responder
        int w;
        w = 0;
        mem_ack = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_ack = 0;
            if (reset && (mem_rd || mem_wr) && !mem_hold) begin
                if (w >= mem_dly) begin
                    mem_ack = 1;
                    w = 0;
                    l_addr = mem_addr;
                    l_wdata = mem_wdata;
                    l_bval = mem_bval;
                    if (mem_rd) begin
                        n_mrd++;
                        mem_rdata = mem_get(mem_addr);
                    end else begin
                        n_mwr++;
                        mem_m[mem_addr] = bmerge(mem_get(mem_addr), mem_wdata, mem_bval);
                    end
                end else w++;
            end else begin
                w = 0;
                if (stray_en && !mem_rd && !mem_wr && $urandom_range(7) == 0) begin
                    mem_ack = 1;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // cache reference model
    bit          mv [256];
    logic [7:0]  mt [256];
    logic [31:0] md [256];
    int          mhit = 0, mmiss = 0;
    logic [31:0] mrdata = 0;

    function automatic int sat(input int x);
        return x < 65535 ? x + 1 : x;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mv[i] = 0;
        mhit = 0;
        mmiss = 0;
        mrdata = 0;
    endtask

    task automatic run(input bit r, input bit w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] b, input int dly, input bit noise);
        logic [7:0] idx, tg;
        bit hit, exp_r, exp_w;
        int exp_lat, lat, n0r, n0w;
        idx = a[7:0];
        tg = a[15:8];
        hit = mv[idx] && mt[idx] == tg;
        exp_r = !w && !hit;
        exp_w = w && b != 0;
        exp_lat = (exp_r || exp_w) ? 3 + dly : 2;
        if (!w) begin
            if (!hit) begin
                md[idx] = mem_get(a);
                mt[idx] = tg;
                mv[idx] = 1;
            end
            mrdata = md[idx];
        end else if (hit && b != 0) md[idx] = bmerge(md[idx], d, b);
        if (hit) mhit = sat(mhit);
        else mmiss = sat(mmiss);
        n0r = n_mrd;
        n0w = n_mwr;
        mem_dly = dly;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d; bval = b;
        @(negedge clk);
        rd = 0; wr = 0; addr = $urandom; wdata = $urandom; bval = $urandom;
        lat = 1;
        while (!ack && lat < 60) begin
            if (noise) begin
                rd = $urandom_range(1);
                wr = $urandom_range(1);
            end
            @(negedge clk);
            lat++;
        end
        rd = 0; wr = 0;
        chk("ack_latency", lat, exp_lat);
        chk("rdata", rdata, mrdata);
        chk("hit_cnt", {16'd0, hit_cnt}, mhit);
        chk("miss_cnt", {16'd0, miss_cnt}, mmiss);
        chk("mem_rd_count", n_mrd - n0r, {31'd0, exp_r});
        chk("mem_wr_count", n_mwr - n0w, {31'd0, exp_w});
        if (exp_r || exp_w) chk("mem_addr", {16'd0, l_addr}, {16'd0, a});
        if (exp_w) begin
            chk("mem_wdata", l_wdata, d);
            chk("mem_bval", {28'd0, l_bval}, {28'd0, b});
        end
        @(negedge clk);
        chk("ack_pulse", {31'd0, ack}, 0);
    endtask

    typedef struct {
        bit r, w;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        int dly;
        bit hit;
        logic [31:0] rdata;
    } vec_t;

    vec_t v [11];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] h0;
        int c;
        bit ack_seen;
        logic [7:0] idx_set [4];
        logic [7:0] tag_set [3];
        v[0]  = '{1, 0, 16'h1234, 32'h0,        4'hF, 1, 0, 32'hDEADBEEF};
        v[1]  = '{1, 0, 16'h1234, 32'h0,        4'hF, 0, 1, 32'hDEADBEEF};
        v[2]  = '{0, 1, 16'h1234, 32'h000000AA, 4'h1, 2, 1, 32'hDEADBEEF};
        v[3]  = '{1, 0, 16'h1234, 32'h0,        4'hF, 0, 1, 32'hDEADBEAA};
        v[4]  = '{0, 1, 16'h5634, 32'h11223344, 4'hF, 0, 0, 32'hDEADBEAA};
        v[5]  = '{1, 0, 16'h1234, 32'h0,        4'hF, 1, 1, 32'hDEADBEAA};
        v[6]  = '{0, 1, 16'h1234, 32'hFFFFFFFF, 4'h0, 0, 1, 32'hDEADBEAA};
        v[7]  = '{1, 0, 16'h5634, 32'h0,        4'hF, 0, 0, 32'h11223344};
        v[8]  = '{1, 0, 16'h1234, 32'h0,        4'hF, 3, 0, 32'hDEADBEAA};
        v[9]  = '{1, 1, 16'h1234, 32'h00005500, 4'h2, 1, 1, 32'hDEADBEAA};
        v[10] = '{1, 0, 16'h1234, 32'h0,        4'hF, 0, 1, 32'hDEAD55AA};
        mem_m[16'h1234] = 32'hDEADBEEF;
        mem_m[16'h5634] = 32'h0;
        model_clear();

        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 0);
        chk("rst_hit_cnt", {16'd0, hit_cnt}, 0);
        chk("rst_miss_cnt", {16'd0, miss_cnt}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_bval", {28'd0, mem_bval}, 0);
        reset = 1;

        for (int i = 0; i < 11; i++) begin
            h0 = hit_cnt;
            run(v[i].r, v[i].w, v[i].a, v[i].d, v[i].b, v[i].dly, 0);
            chk($sformatf("vec%0d_rdata", i), rdata, v[i].rdata);
            chk($sformatf("vec%0d_hit", i), {16'd0, hit_cnt - h0}, {31'd0, v[i].hit});
        end

        // reset while a read miss is waiting on memory
        mem_hold = 1;
        @(negedge clk);
        rd = 1; addr = 16'h5634;
        @(negedge clk);
        rd = 0;
        c = 0;
        while (!mem_rd && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("midrst_mem_rd_issued", {31'd0, mem_rd}, 1);
        reset = 0;
        #1;
        chk("midrst_mem_rd_drop", {31'd0, mem_rd}, 0);
        chk("midrst_hit_cnt", {16'd0, hit_cnt}, 0);
        chk("midrst_miss_cnt", {16'd0, miss_cnt}, 0);
        ack_seen = 0;
        repeat (3) begin
            @(negedge clk);
            ack_seen |= ack;
        end
        mem_hold = 0;
        reset = 1;
        repeat (3) begin
            @(negedge clk);
            ack_seen |= ack;
        end
        chk("midrst_no_ack", {31'd0, ack_seen}, 0);
        model_clear();
        run(1, 0, 16'h1234, 0, 4'hF, 1, 0);
        chk("midrst_read_misses", {16'd0, miss_cnt}, 1);

        // randomized traffic over a few indices and tags to force conflicts
        idx_set = '{8'h34, 8'h00, 8'hFF, 8'h12};
        tag_set = '{8'h12, 8'h56, 8'hA0};
        stray_en = 1;
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(2);
            run(op != 1, op != 0, {tag_set[$urandom_range(2)], idx_set[$urandom_range(3)]},
                $urandom, 4'($urandom), $urandom_range(3), 1'($urandom_range(1)));
        end
        stray_en = 0;

        // counter saturation
        run(1, 0, 16'h1234, 0, 4'hF, 0, 0);
        @(negedge clk);
        force dut.hit_cnt = 16'hFFFE;
        force dut.miss_cnt = 16'hFFFF;
        #1;
        release dut.hit_cnt;
        release dut.miss_cnt;
        mhit = 65534;
        mmiss = 65535;
        run(1, 0, 16'h1234, 0, 4'hF, 0, 0);
        chk("sat_hit_reach", {16'd0, hit_cnt}, 32'hFFFF);
        run(1, 0, 16'h1234, 0, 4'hF, 0, 0);
        chk("sat_hit_hold", {16'd0, hit_cnt}, 32'hFFFF);
        run(1, 0, 16'h9934, 0, 4'hF, 2, 0);
        chk("sat_miss_hold", {16'd0, miss_cnt}, 32'hFFFF);
        run(1, 1, 16'h9934, 32'hCAFEF00D, 4'hC, 0, 0);
        run(1, 0, 16'h9934, 0, 4'hF, 0, 0);
        chk("rdwr_as_write", rdata, bmerge(mem_get(16'h9934), 32'hCAFEF00D, 4'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
